// File: rtl/seq_left_shifter_16b_pkg.sv
// Shared constants for the sequential left shifter: FSM state encodings and
// the per-cycle step sizes of the coarse and fine shift stages.
package seq_left_shifter_16b_pkg;

  // FSM state encodings (kept as plain 2-bit constants for legacy tools).
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COARSE = 2'd1;
  localparam logic [1:0] S_FINE   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Shift distance applied per cycle in each busy state.
  localparam int STEP_COARSE = 4;
  localparam int STEP_FINE   = 1;

endpackage

// File: rtl/seq_left_shifter_16b_shift_step_4_1.sv
// shift_step_4_1: combinational single-step left shifter.
// Shifts acc left by STEP_COARSE (sel_coarse=1) or STEP_FINE (sel_coarse=0).
// Vacated low bits are zero, or the shifted-out bits when fill_en=1 (rotate).
// cout carries the bits that left the MSB end, right-aligned.
module shift_step_4_1
  import seq_left_shifter_16b_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]       acc,
  input  logic                   sel_coarse,
  input  logic                   fill_en,
  output logic [WIDTH-1:0]       shifted,
  output logic [STEP_COARSE-1:0] cout
);

  logic [STEP_COARSE-1:0] top_coarse;
  logic                   top_fine;

  assign top_coarse = acc[WIDTH-1 -: STEP_COARSE];
  assign top_fine   = acc[WIDTH-1];

  // Select the coarse or fine shift and its shifted-out bits.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = acc;
    cout    = '0;
    if (sel_coarse) begin
      shifted = {acc[WIDTH-1-STEP_COARSE:0], top_coarse & {STEP_COARSE{fill_en}}};
      cout    = top_coarse;
    end else begin
      shifted = {acc[WIDTH-1-STEP_FINE:0], top_fine & fill_en};
      cout    = {{(STEP_COARSE-STEP_FINE){1'b0}}, top_fine};
    end
  end

endmodule

// File: rtl/seq_left_shifter_16b.sv
// seq_left_shifter_16b: multi-cycle left shifter with start/busy/done handshake.
// Shifts 4 bits per cycle while at least 4 remain, then 1 bit per cycle.
// Optional build macro SEQ_SHIFT_ROTATE_EN adds a 'rot' input selecting
// rotate-left (ovf held 0) instead of zero-fill logical shift.
module seq_left_shifter_16b
  import seq_left_shifter_16b_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [SHW-1:0] COARSE_AMT = SHW'(STEP_COARSE);
  localparam logic [SHW-1:0] FINE_AMT   = SHW'(STEP_FINE);

  logic [1:0]             state;
  logic [WIDTH-1:0]       acc;
  logic [SHW-1:0]         rem;
  logic [SHW-1:0]         rem_next;
  logic [WIDTH-1:0]       step_acc;
  logic [STEP_COARSE-1:0] step_cout;
  logic                   rot_q;

`ifndef SEQ_SHIFT_ROTATE_EN
  assign rot_q = 1'b0;
`endif

  assign busy = (state == S_COARSE) || (state == S_FINE);

  shift_step_4_1 #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .sel_coarse (state == S_COARSE),
    .fill_en    (rot_q),
    .shifted    (step_acc),
    .cout       (step_cout)
  );

  // Remaining shift count after this cycle's step.
  always_comb begin
    rem_next = rem;
    if (state == S_COARSE)    rem_next = rem - COARSE_AMT;
    else if (state == S_FINE) rem_next = rem - FINE_AMT;
  end

  // Control FSM, shift accumulator, sticky overflow and result register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: acc and dout are plain registers, so reset clears them; aborted results never leak out.
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      dout  <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= din;
            rem <= amt;
            ovf <= 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
            rot_q <= rot;
`endif
            if (amt >= COARSE_AMT) state <= S_COARSE;
            else if (amt != '0)    state <= S_FINE;
            else                   state <= S_DONE;
          end
        end
        S_COARSE: begin
          acc <= step_acc;
          rem <= rem_next;
          if (!rot_q) ovf <= ovf | (|step_cout);
          if (rem_next >= COARSE_AMT) state <= S_COARSE;
          else if (rem_next != '0)    state <= S_FINE;
          else                        state <= S_DONE;
        end
        S_FINE: begin
          acc <= step_acc;
          rem <= rem_next;
          if (!rot_q) ovf <= ovf | (|step_cout);
          if (rem_next == '0) state <= S_DONE;
        end
        default: begin
          // S_DONE: publish the result with a one-cycle done pulse.
          done  <= 1'b1;
          dout  <= acc;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_left_shifter_16b.sv
// Directed self-checking bench for seq_left_shifter_16b (WIDTH=16).
// Rotate vectors run only when SEQ_SHIFT_ROTATE_EN is defined.
module tb_seq_left_shifter_16b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [3:0]  amt;
  logic        rot;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic        ovf;

  int tests    = 0;
  int failures = 0;

  seq_left_shifter_16b #(.WIDTH(16), .SHW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
`ifdef SEQ_SHIFT_ROTATE_EN
    .rot   (rot),
`endif
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check result, latency and busy profile.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic r, input logic [15:0] exp_dout, input logic exp_ovf,
                        input int exp_n);
    int n;
    int busy_cnt;
    @(negedge clk);
    din = d; amt = a; rot = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din = 16'hDEAD; amt = 4'hF; rot = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_n);
    check({tag, " dout"}, dout, exp_dout);
    check({tag, " ovf"}, ovf, exp_ovf);
    check({tag, " busy cycles"}, busy_cnt, exp_n - 1);
    check({tag, " busy with done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, done, 0);
    check({tag, " dout held"}, dout, exp_dout);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; amt = '0; rot = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", dout, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    // Plan vectors 1-3 plus extra patterns.
    run_op("amt0",  16'h1234, 4'd0,  1'b0, 16'h1234, 1'b0, 1);
    run_op("amt8",  16'h1234, 4'd8,  1'b0, 16'h3400, 1'b1, 3);
    run_op("amt15", 16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0, 7);
    run_op("amt3",  16'hF00F, 4'd3,  1'b0, 16'h8078, 1'b1, 4);
    run_op("amt4",  16'h0FFF, 4'd4,  1'b0, 16'hFFF0, 1'b0, 2);

    // Vector 4: start pulsed while busy is ignored.
    @(negedge clk);
    din = 16'h8001; amt = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    check("busy-start busy", busy, 1);
    din = 16'hFFFF; amt = 4'd15;                 // start still high while FINE
    @(posedge clk); #1;
    start = 1'b0;
    check("busy-start no done early", done, 0);
    @(posedge clk); #1;
    check("busy-start done", done, 1);
    check("busy-start dout", dout, 16'h0002);
    check("busy-start ovf", ovf, 1);
    repeat (4) begin
      @(posedge clk); #1;
      check("busy-start no extra done", done, 0);
      check("busy-start no extra busy", busy, 0);
    end
    check("busy-start dout stable", dout, 16'h0002);

    // Vector 5: reset during the second COARSE cycle aborts the operation.
    @(negedge clk);
    din = 16'hABCD; amt = 4'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort in coarse", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort dout", dout, 0);
    check("abort ovf", ovf, 0);
    check("abort done", done, 0);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort no done", done, 0);
    end
    run_op("after abort", 16'h00F0, 4'd4, 1'b0, 16'h0F00, 1'b0, 2);

    // Simultaneous rst and start: start is not accepted.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; din = 16'h0F0F; amt = 4'd4;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", busy, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("rst+start no done", done, 0);
    end
    check("rst+start dout", dout, 0);

`ifdef SEQ_SHIFT_ROTATE_EN
    // Vector 6: rotate versus logical shift.
    run_op("rot1",     16'h8001, 4'd4, 1'b1, 16'h0018, 1'b0, 2);
    run_op("rot0",     16'h8001, 4'd4, 1'b0, 16'h0010, 1'b1, 2);
    run_op("rot1 amt5", 16'h8001, 4'd5, 1'b1, 16'h0030, 1'b0, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/seq_left_shifter_16b.md
Name: seq_left_shifter_16b

Overview:
- Multi-cycle left-shift unit for the datapath component library.
- Loads a word and a shift amount, then shifts by 4 bits per cycle while at least 4 bits remain, then by 1 bit per cycle for the remainder.
- Handshake is start/busy/done. Trades latency for area against a full barrel shifter.
- Feeds the ALU result path; the 4-bit and 1-bit step logic is the same kind of stage as the nibble shifter blocks.

Parameters:
- WIDTH, 16, data width; must be a multiple of 4 and at least 8.
- SHW, 4, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- din  input  WIDTH  operand, captured when start is accepted
- amt  input  SHW  shift amount 0..WIDTH-1, captured with din
- dout  output  WIDTH  result; valid when done=1, held until the next accepted start
- busy  output  1  high while shifting (COARSE or FINE)
- done  output  1  one-cycle pulse; result valid
- ovf  output  1  sticky OR of every bit shifted out of the MSB during the operation

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. Forces state=IDLE, acc=0, rem=0, dout=0, busy=0, done=0, ovf=0. Reset mid-operation aborts it: no done, and dout reads 0 the cycle after.
- States: IDLE, COARSE, FINE, DONE.
- IDLE, start=1:
  - acc<=din, rem<=amt, ovf<=0.
  - Next state is COARSE if amt>=4, else FINE if amt>0, else DONE.
- COARSE:
  - acc<=acc<<4 with zero fill; ovf|=|acc[WIDTH-1:WIDTH-4]; rem<=rem-4.
  - Stay while the new rem>=4; else go to FINE if the new rem>0, else DONE.
- FINE:
  - acc<=acc<<1 with zero fill; ovf|=acc[WIDTH-1]; rem<=rem-1.
  - Go to DONE when the new rem==0.
- DONE: done=1 for exactly one cycle, dout=acc; return to IDLE.
- DONE does not accept start; a start raised in DONE must be held into IDLE.
- Latency: done is high N edges after the start-sampling edge, where N = 1 + amt[SHW-1:2] + amt[1:0]. Examples: amt=0 gives N=1; amt=15 gives N=7 for WIDTH=16.
- busy=1 exactly in COARSE and FINE. done and busy are never high together.
- start outside IDLE is ignored, with no queuing. din and amt are don't-care except on the accepting edge.
- dout updates only on entry to DONE. It is stable through IDLE and while busy.
- Simultaneous rst and start: rst wins; start is not accepted.

Optional Feature:
- Macro: SEQ_SHIFT_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit), captured with din on start.
  - With rot=1, vacated low bits are filled with the bits shifted out (rotate left), and ovf is held 0.
  - With rot=0, behaviour is identical to the undefined case.
- Undefined: rot port absent; logical shift only, zero fill.
- Latency is identical in both builds.

Decomposition:
- Shared include seq_shift_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_COARSE=2'd1, S_FINE=2'd2, S_DONE=2'd3;
  - step constants STEP_COARSE=4, STEP_FINE=1.
- Sub-module shift_step_4_1 is combinational and natural to split out:
  - Inputs: acc, sel_coarse, fill_en.
  - Outputs: the shifted word and the shifted-out bits, as 4-bit cout.
  - The FSM/counter stays in the top module.

Test Plan (WIDTH=16):
1. din=16'h1234, amt=0, start → done 1 edge later, dout=16'h1234, ovf=0, busy never high.
2. din=16'h1234, amt=8 → busy for 2 cycles, done at edge 3, dout=16'h3400, ovf=1.
3. din=16'h0001, amt=15 → done at edge 7 (3 coarse + 3 fine), dout=16'h8000, ovf=0.
4. din=16'h8001, amt=1, then start with din=16'hFFFF pulsed while busy → done at edge 2, dout=16'h0002, ovf=1, second start ignored, no extra done.
5. din=16'hABCD, amt=12, rst asserted on the 2nd COARSE cycle → next cycle state IDLE, busy=0, dout=0, ovf=0, no done pulse; a new start afterwards completes normally.
6. SEQ_SHIFT_ROTATE_EN defined, rot=1, din=16'h8001, amt=4 → done at edge 2, dout=16'h0018, ovf=0; same stimulus with rot=0 → dout=16'h0010, ovf=1.
